// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mult_accumulator
// Description : Multiply-accumulate back end for the carry-save array
//               multiplier. Accepts TERMS unsigned 2N-bit products over a
//               valid/ready handshake. Sums them into a saturating ACC_W-bit
//               accumulator with a sticky overflow flag. Presents the result
//               over a second valid/ready handshake.
// Ports       : clk        - rising-edge clock
//               rst_n      - synchronous active-low reset
//               start      - pulse, begins a new accumulation (IDLE / HOLD)
//               prod_valid - product on prod is valid
//               prod       - 2N-bit unsigned product
//               prod_ready - block accepts a product (ACCUM state)
//               acc_out    - accumulated (saturated) sum
//               acc_valid  - acc_out holds a completed result (HOLD state)
//               acc_ready  - downstream accepts the result
//               ovf        - sticky overflow flag of current accumulation
//               busy       - high in ACCUM or HOLD
//               term_cnt   - number of products accepted so far
// Revision    : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 10,
  parameter int TERMS = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           prod_valid,
  input  logic [2*N-1:0]                 prod,
  output logic                           prod_ready,
  output logic [ACC_W-1:0]               acc_out,
  output logic                           acc_valid,
  input  logic                           acc_ready,
  output logic                           ovf,
  output logic                           busy,
  output logic [$clog2(TERMS+1)-1:0]     term_cnt
);

  localparam int CNT_W = $clog2(TERMS + 1);
  // Zero padding that widens a product to the ACC_W+1 bit sum width.
  localparam int PAD_W = ACC_W + 1 - 2 * N;
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q,   acc_d;
  logic                   ovf_q,   ovf_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [ACC_W:0]         w_sum;

  // One extra bit catches the carry out of the accumulator.
  assign w_sum = {1'b0, acc_q} + {{PAD_W{1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        // prod_ready is high throughout ACCUM, so prod_valid alone
        // qualifies a transfer.
        if (prod_valid) begin
          // Once overflowed, stay pinned at all ones for the rest of
          // the accumulation.
          if (w_sum[ACC_W] || ovf_q) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = w_sum[ACC_W-1:0];
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_IDX) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (acc_ready) begin
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign prod_ready = (state_q == S_ACCUM);
  assign acc_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;
  assign term_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_accumulator
// Description : Self-checking bench for mult_accumulator. A reference model
//               keeps the running product total as a plain integer. The
//               expected accumulator value is min(total, 2^ACC_W-1), and the
//               expected overflow flag is total > 2^ACC_W-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 10;
  localparam int TERMS = 5;
  localparam int CW    = $clog2(TERMS + 1);
  localparam int MAXV  = (1 << ACC_W) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ACCUM = 1;
  localparam int P_HOLD  = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             prod_valid;
  logic [2*N-1:0]   prod;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;
  logic             busy;
  logic [CW-1:0]    term_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ph    = P_IDLE;
  int m_total = 0;
  int m_cnt   = 0;

  mult_accumulator #(.N(N), .ACC_W(ACC_W), .TERMS(TERMS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .ovf        (ovf),
    .busy       (busy),
    .term_cnt   (term_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the spec's rules.
  task automatic model_edge(input logic s, input logic pv, input int p,
                            input logic ar, input logic rn);
    if (!rn) begin
      m_ph = P_IDLE; m_total = 0; m_cnt = 0;
    end else if (m_ph == P_IDLE) begin
      if (s) begin m_ph = P_ACCUM; m_total = 0; m_cnt = 0; end
    end else if (m_ph == P_ACCUM) begin
      if (pv) begin
        m_total += p;
        m_cnt++;
        if (m_cnt == TERMS) m_ph = P_HOLD;
      end
    end else begin
      if (ar) begin
        if (s) begin m_ph = P_ACCUM; m_total = 0; m_cnt = 0; end
        else m_ph = P_IDLE;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_acc;
    exp_acc = (m_total > MAXV) ? MAXV : m_total;
    chk({tag, ".acc_out"},    int'(acc_out),    exp_acc);
    chk({tag, ".ovf"},        int'(ovf),        (m_total > MAXV) ? 1 : 0);
    chk({tag, ".term_cnt"},   int'(term_cnt),   m_cnt);
    chk({tag, ".prod_ready"}, int'(prod_ready), (m_ph == P_ACCUM) ? 1 : 0);
    chk({tag, ".acc_valid"},  int'(acc_valid),  (m_ph == P_HOLD) ? 1 : 0);
    chk({tag, ".busy"},       int'(busy),       (m_ph != P_IDLE) ? 1 : 0);
  endtask

  // Drive inputs, clock once, update the model, sample 1ns after the edge.
  task automatic tick(input string tag, input logic s, input logic pv,
                      input int p, input logic ar, input logic rn);
    start      = s;
    prod_valid = pv;
    prod       = (2*N)'(p);
    acc_ready  = ar;
    rst_n      = rn;
    @(posedge clk);
    model_edge(s, pv, p, ar, rn);
    #1;
    check_all(tag);
  endtask

  initial begin
    start = 0; prod_valid = 0; prod = '0; acc_ready = 0; rst_n = 0;

    // Reset then idle with prod_valid toggling
    tick("rst", 0, 0, 0, 0, 0);
    tick("rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("idle", 0, i[0], 99, 0, 1);
    chk("idle.acc_zero", int'(acc_out), 0);
    chk("idle.cnt_zero", int'(term_cnt), 0);

    // Back-to-back, no overflow
    tick("b2b.start", 1, 0, 0, 1, 1);
    for (int i = 0; i < TERMS; i++) tick("b2b", 0, 1, 200, 1, 1);
    chk("b2b.sum", int'(acc_out), 1000);
    chk("b2b.valid_at_6", int'(acc_valid), 1);
    tick("b2b.drain", 0, 0, 0, 1, 1);
    chk("b2b.valid_one_cycle", int'(acc_valid), 0);

    // Saturation and its boundary
    tick("sat.start", 1, 0, 0, 0, 1);
    for (int i = 0; i < TERMS - 1; i++) tick("sat", 0, 1, 225, 0, 1);
    chk("sat.boundary_acc", int'(acc_out), 900);
    chk("sat.boundary_ovf", int'(ovf), 0);
    tick("sat.last", 0, 1, 225, 0, 1);
    chk("sat.acc", int'(acc_out), MAXV);
    chk("sat.ovf", int'(ovf), 1);
    tick("sat.drain", 0, 0, 0, 1, 1);

    // Bubbles and backpressure
    begin
      int bp[5] = '{10, 0, 15, 7, 3};
      tick("bub.start", 1, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
        tick("bub", 0, 1, bp[i], 0, 1);
        tick("bub.gap", 0, 0, 77, 0, 1);
      end
      for (int i = 0; i < 4; i++) tick("bub.stall", 0, 0, 0, 0, 1);
      chk("bub.sum", int'(acc_out), 35);
      chk("bub.cnt", int'(term_cnt), 5);
      chk("bub.valid", int'(acc_valid), 1);
      tick("bub.drain", 0, 0, 0, 1, 1);
    end

    // Restart in HOLD; start in ACCUM ignored
    tick("rs.start", 1, 0, 0, 0, 1);
    tick("rs", 0, 1, 50, 0, 1);
    tick("rs.start_in_accum", 1, 1, 60, 0, 1);
    chk("rs.ignored_start_cnt", int'(term_cnt), 2);
    for (int i = 0; i < TERMS - 2; i++) tick("rs", 0, 1, 70, 0, 1);
    tick("rs.hold_start_no_ready", 1, 0, 0, 0, 1);
    chk("rs.hold_kept", int'(acc_valid), 1);
    tick("rs.restart", 1, 0, 0, 1, 1);
    chk("rs.busy", int'(busy), 1);
    chk("rs.prod_ready", int'(prod_ready), 1);
    chk("rs.acc_clear", int'(acc_out), 0);
    chk("rs.cnt_clear", int'(term_cnt), 0);

    // Reset mid-operation: finish the restarted accumulation with 3 terms
    for (int i = 0; i < 3; i++) tick("mid", 0, 1, 9, 0, 1);
    tick("mid.rst", 0, 1, 9, 0, 0);
    chk("mid.acc_zero", int'(acc_out), 0);
    for (int i = 0; i < 6; i++) begin
      tick("mid.after", 0, 1, 9, 1, 1);
      chk("mid.no_valid", int'(acc_valid), 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic s, pv, ar, rn;
      s  = ($urandom_range(0, 9) == 0);
      pv = ($urandom_range(0, 9) < 6);
      ar = ($urandom_range(0, 9) < 4);
      rn = ($urandom_range(0, 99) != 0);
      tick("rnd", s, pv, int'($urandom_range(0, 255)), ar, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream consumer of the carry-save array multiplier built from the multiplier cells. Sits after the array's final product row.
- Accepts 2N-bit unsigned products over a valid/ready handshake and accumulates exactly TERMS of them into an ACC_W-bit register.
- Detects overflow; on overflow the accumulator saturates.
- Presents the finished sum downstream over a second valid/ready handshake, forming a multiply-accumulate (dot-product) engine.

Parameters:
- N, 4: multiplier operand width; product width is 2N.
- ACC_W, 10: accumulator width; must be >= 2N.
- TERMS, 5: number of products per accumulation; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a new accumulation.
- prod_valid  input  1  product on prod is valid.
- prod  input  2N  unsigned product from the multiplier array.
- prod_ready  output  1  block accepts a product this cycle.
- acc_out  output  ACC_W  accumulated sum (saturated on overflow).
- acc_valid  output  1  acc_out holds a completed result.
- acc_ready  input  1  downstream accepts the result.
- ovf  output  1  sticky overflow flag for the current accumulation.
- busy  output  1  high in ACCUM or HOLD.
- term_cnt  output  clog2(TERMS+1)  number of products accepted so far.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low.
  - While rst_n=0 at a rising edge: state=IDLE, acc_out=0, term_cnt=0, ovf=0, acc_valid=0, prod_ready=0, busy=0.
  - Reset asserted mid-accumulation discards all partial state; no result is emitted.
- All outputs are registered. prod_ready, acc_valid and busy decode directly from the state register.
- IDLE:
  - prod_ready=0, acc_valid=0. acc_out and ovf keep the last result.
  - start=1 -> ACCUM; acc_out<=0, ovf<=0, term_cnt<=0.
  - prod_valid is ignored in IDLE.
- ACCUM:
  - prod_ready=1.
  - A transfer occurs when prod_valid and prod_ready are both high. On each transfer:
    - sum = acc_out + zero-extended prod, computed at ACC_W+1 bits.
    - If bit ACC_W of sum is 1, or ovf is already 1: acc_out<=all ones and ovf<=1.
    - Otherwise acc_out<=sum[ACC_W-1:0].
    - term_cnt increments.
  - On the transfer that makes term_cnt==TERMS -> HOLD. The product on that transfer is included in the sum.
  - No transfer in a cycle: all state holds.
  - start in ACCUM is ignored.
- HOLD:
  - acc_valid=1, prod_ready=0. acc_out, ovf and term_cnt are stable.
  - acc_ready=1 -> IDLE; acc_valid drops the next cycle.
  - If start=1 in the same cycle as acc_ready=1 -> ACCUM directly, with the accumulator cleared as in IDLE.
  - start without acc_ready is ignored.
- Latency and throughput:
  - Each accepted product is reflected in acc_out one cycle after its transfer.
  - acc_valid rises the cycle after the TERMS-th transfer.
  - Maximum throughput is one product per cycle.
  - Minimum start-to-acc_valid time is TERMS+1 cycles.
- TERMS=1: the first transfer moves the block straight to HOLD.
- Saturation is sticky within an accumulation. Later products cannot unsaturate acc_out.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then start=0 and prod_valid toggling -> all outputs 0, prod_ready=0, term_cnt stays 0.
- Back-to-back no overflow: start, then 5 consecutive valid products of 200 with acc_ready=1 -> acc_out=1000, ovf=0, acc_valid high for exactly 1 cycle, 6 cycles after start.
- Saturation: start, 5 products of 225 -> after the 5th, acc_out=1023, ovf=1. Also check the boundary: 4 products of 225 give acc_out=900, ovf=0 after the 4th transfer.
- Bubbles and backpressure: products 10,0,15,7,3 with prod_valid deasserted on alternate cycles and acc_ready held low for 4 cycles -> acc_out=35, acc_valid held stable with no change during the stall, term_cnt=5.
- Restart in HOLD: in HOLD assert acc_ready and start together -> next cycle busy=1, prod_ready=1, acc_out=0, ovf=0, term_cnt=0. A start asserted while in ACCUM has no effect.
- Reset mid-operation: after 3 of 5 products, rst_n=0 for 1 cycle -> IDLE, acc_out=0, and acc_valid never asserts for that accumulation.
